mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 151 +++++++++++++++
 tb/tb_mult_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier that does its arithmetic through an external combinational ALU.
// MULT_EARLY_EXIT_EN: when defined, finish as soon as the remaining multiplier reaches zero.
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcnd,
    input  logic [31:0] mplr,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod,
    output logic [4:0]  opcd,
    output logic [31:0] inps,
    output logic [31:0] inpt,
    output logic [31:0] inpi,
    output logic [31:0] inpm,
    input  logic [31:0] aout
);

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

    localparam logic [4:0] OP_ADD = 5'b01000;
    localparam logic [4:0] OP_SHL = 5'b01110;
    localparam logic [4:0] OP_SHR = 5'b01111;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] prod_q, prod_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [4:0]  opcd_q, opcd_d;
    logic [31:0] inps_q, inps_d, inpt_q, inpt_d, inpi_q, inpi_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = mcnd;
                    b_d     = mplr;
                    p_d     = 32'd0;
                    cnt_d   = 6'd0;
                    state_d = mplr[0] ? S_ADD : S_SHL;
`ifdef MULT_EARLY_EXIT_EN
                    if (mplr == 32'd0) state_d = S_DONE;
`endif
                end
            end
            S_ADD: begin
                p_d     = aout;
                state_d = S_SHL;
            end
            S_SHL: begin
                a_d     = aout;
                state_d = S_SHR;
            end
            S_SHR: begin
                b_d   = aout;
                cnt_d = cnt_q + 6'd1;
                if (cnt_d == 6'd32)
                    state_d = S_DONE;
`ifdef MULT_EARLY_EXIT_EN
                else if (aout == 32'd0)
                    state_d = S_DONE;
`endif
                else
                    state_d = aout[0] ? S_ADD : S_SHL;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        opcd_d = 5'd0;
        inps_d = 32'd0;
        inpt_d = 32'd0;
        inpi_d = 32'd0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_ADD: begin
                opcd_d = OP_ADD;
                inps_d = p_d;
                inpt_d = a_d;
                busy_d = 1'b1;
            end
            S_SHL: begin
                opcd_d = OP_SHL;
                inps_d = a_d;
                inpi_d = 32'd1;
                busy_d = 1'b1;
            end
            S_SHR: begin
                opcd_d = OP_SHR;
                inps_d = b_d;
                inpi_d = 32'd1;
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                prod_d = p_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            p_q     <= 32'd0;
            cnt_q   <= 6'd0;
            prod_q  <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            opcd_q  <= 5'd0;
            inps_q  <= 32'd0;
            inpt_q  <= 32'd0;
            inpi_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            opcd_q  <= opcd_d;
            inps_q  <= inps_d;
            inpt_q  <= inpt_d;
            inpi_q  <= inpi_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;
    assign opcd = opcd_q;
    assign inps = inps_q;
    assign inpt = inpt_q;
    assign inpi = inpi_q;
    assign inpm = 32'd0;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: behavioural ALU, arithmetic reference for product and cycle counts.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mcnd = '0, mplr = '0;
    logic        busy, done;
    logic [31:0] prod, inps, inpt, inpi, inpm, aout;
    logic [4:0]  opcd;

    int checks = 0;
    int errors = 0;

    mult_seq dut (
        .clk(clk), .rst(rst), .start(start), .mcnd(mcnd), .mplr(mplr),
        .busy(busy), .done(done), .prod(prod), .opcd(opcd),
        .inps(inps), .inpt(inpt), .inpi(inpi), .inpm(inpm), .aout(aout)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (opcd)
            5'b01000: aout = inps + inpt;
            5'b01110: aout = inps << inpi;
            5'b01111: aout = inps >> inpi;
            default:  aout = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int exp_busy(input logic [31:0] m);
`ifdef MULT_EARLY_EXIT_EN
        int top = -1;
        for (int i = 0; i < 32; i++) if (m[i]) top = i;
        return 2 * (top + 1) + popcount(m);
`else
        return 64 + popcount(m);
`endif
    endfunction

    // Run one multiplication; if inject is set, pulse start with junk operands 5 cycles in.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject, input string tag);
        logic [31:0] exp_prod;
        int cycles, nbusy;
        exp_prod = a * b;
        @(negedge clk);
        mcnd = a; mplr = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        nbusy = 0;
        while (!done && cycles < 200) begin
            if (busy) nbusy++;
            @(negedge clk);
            if (inject && cycles == 4) begin
                mcnd = $urandom; mplr = $urandom; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            cycles++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(done), 64'd1);
        check({tag, " prod"}, 64'(prod), 64'(exp_prod));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_busy(b)));
        check({tag, " latency"}, 64'(cycles), 64'(nbusy + 1));
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check({tag, " opcd_in_done"}, 64'(opcd), 64'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        @(negedge clk);
        check({tag, " prod_held"}, 64'(prod), 64'(exp_prod));
    endtask

    initial begin
        logic [31:0] ra, rb;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", 64'(prod), 64'd0);
        check("rst_alu", {27'd0, opcd, inps}, 64'd0);
        check("rst_alu2", {inpt, inpi}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, "3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ones");
        run_op(32'h1234_5678, 32'd0, 1'b0, "mplr0");
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "trunc");
        run_op(32'd11, 32'd13, 1'b1, "ignored_start");
        check("inpm_zero", 64'(inpm), 64'd0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb & 32'h0000_0FFF;
            if (i % 5 == 2) rb = rb & 32'h8000_0001;
            run_op(ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        mcnd = 32'd7; mplr = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_prod", 64'(prod), 64'd0);
        check("midrst_opcd", 64'(opcd), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd7, 32'd9, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
